// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_pkg
// Description : Shared types and constants for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_controller_pkg;

  // Fetch sequencer states (2-bit encoding, all four codes used).
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0), parked in the buffer when it is cleared.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Instruction fetch targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_controller_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_buffer
// Description : Holding register for the fetched instruction word and its PC,
//               with a valid flag. Clear has priority over load.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller_buffer
  import fetch_controller_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  // Capture the word on load, drop it on clear; reset empties it asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_NOP;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Sequences the program counter and instruction memory: one read
//               per PC, holds the word until decode accepts it, applies
//               redirects from execute and flags misaligned fetch targets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_out_i,
  output logic [XLEN-1:0] pc_load_data_o,
  output logic            pc_load_en_o,
  output logic            pc_inc_en_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            fetch_err_o
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;

  logic            w_pc_load_en;
  logic            w_pc_inc_en;
  logic [XLEN-1:0] w_pc_load_data;
  logic            w_imem_req;
  logic            w_fetch_err;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic            w_redirect;

  // State register; reset restarts the boot sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; a redirect outside BOOT overrides everything.
  always_comb begin
    state_d        = state_q;
    w_pc_load_en   = 1'b0;
    w_pc_inc_en    = 1'b0;
    w_pc_load_data = RESET_VECTOR;
    w_imem_req     = 1'b0;
    w_fetch_err    = 1'b0;
    w_buf_load     = 1'b0;
    w_buf_clear    = 1'b0;
    w_redirect     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        w_pc_load_en = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready_i) begin
          w_buf_load  = 1'b1;
          w_pc_inc_en = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready_i) begin
          w_buf_clear = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FAULT: begin
        w_fetch_err = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    w_redirect = redirect_valid_i &&
                 ((state_q == ST_FETCH) || (state_q == ST_HOLD) || (state_q == ST_FAULT));

    if (w_redirect) begin
      // Any word landing this cycle is dropped and the held word is released;
      // a coincident decode handshake has already consumed it on the outputs.
      w_pc_load_en   = 1'b1;
      w_pc_load_data = redirect_target_i;
      w_pc_inc_en    = 1'b0;
      w_buf_load     = 1'b0;
      w_buf_clear    = 1'b1;
      state_d        = is_misaligned(redirect_target_i[1:0]) ? ST_FAULT : ST_FETCH;
    end
  end

  fetch_controller_buffer #(
    .XLEN (XLEN)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_buf_load),
    .clear_i (w_buf_clear),
    .instr_i (imem_rdata_i),
    .pc_i    (pc_out_i),
    .valid_o (instr_valid_o),
    .instr_o (instr_o),
    .pc_o    (instr_pc_o)
  );

  // While reset is held the state already reads BOOT; mask its load pulse so
  // every output except the load value sits at zero.
  assign pc_load_en_o   = w_pc_load_en & ~rst;
  assign pc_inc_en_o    = w_pc_inc_en & ~rst;
  assign pc_load_data_o = w_pc_load_data;
  assign imem_req_o     = w_imem_req & ~rst;
  assign imem_addr_o    = rst ? '0 : pc_out_i;
  assign fetch_err_o    = w_fetch_err & ~rst;

endmodule
`default_nettype wire
